wr_arria10_phy_reset_ctrl: RTL

WR_ARRIA10_PHY_RESET_CTRL -- requirements
Module: wr_arria10_phy_reset_ctrl

---
 rtl/wr_arria10_phy_reset_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wr_arria10_phy_reset_ctrl.sv
// ============================================================================
// wr_arria10_phy_reset_ctrl : Arria 10 transceiver TX/RX reset sequencer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_arria10_phy_reset_ctrl #(
  parameter int unsigned g_analog_cycles  = 8,
  parameter int unsigned g_digital_cycles = 4,
  parameter int unsigned g_lock_settle    = 16,
  parameter int unsigned g_lock_timeout   = 100000
) (
  input  logic       clk_sys_i,
  input  logic       rst_n_i,
  input  logic       rst_req_i,
  input  logic       tx_pll_locked_i,
  input  logic       tx_cal_busy_i,
  input  logic       rx_cal_busy_i,
  input  logic       rx_is_lockedtodata_i,
  output logic       tx_analogreset_o,
  output logic       tx_digitalreset_o,
  output logic       rx_analogreset_o,
  output logic       rx_digitalreset_o,
  output logic       tx_ready_o,
  output logic       rx_ready_o,
  output logic [7:0] rx_timeouts_o
);

  localparam logic [19:0] c_ana_last    = 20'(g_analog_cycles - 1);
  localparam logic [19:0] c_dig_last    = 20'(g_digital_cycles - 1);
  localparam logic [19:0] c_settle_last = 20'(g_lock_settle - 1);
  localparam logic [19:0] c_tmo_last    = 20'(g_lock_timeout - 1);

  typedef enum logic [1:0] {
    TX_ANA_RST  = 2'd0,
    TX_WAIT_CAL = 2'd1,
    TX_DIG_RST  = 2'd2,
    TX_READY    = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_ANA_RST   = 3'd0,
    RX_WAIT_CAL  = 3'd1,
    RX_WAIT_LOCK = 3'd2,
    RX_DIG_RST   = 3'd3,
    RX_READY     = 3'd4
  } rx_state_t;

  // Bit order: {tx_pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata}
  logic [3:0] w_async;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic       w_tx_locked;
  logic       w_tx_cal;
  logic       w_rx_cal;
  logic       w_rx_locked;
  logic       w_tx_ok;

  assign w_async     = {tx_pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i};
  assign w_tx_locked = sync2_q[3];
  assign w_tx_cal    = sync2_q[2];
  assign w_rx_cal    = sync2_q[1];
  assign w_rx_locked = sync2_q[0];
  assign w_tx_ok     = w_tx_locked && !w_tx_cal;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_async;
      sync2_q <= sync1_q;
    end
  end

  tx_state_t   tx_state_q, tx_state_d;
  logic [19:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    if (rst_req_i) begin
      tx_state_d = TX_ANA_RST;
      tx_cnt_d   = '0;
    end else begin
      case (tx_state_q)
        TX_ANA_RST: begin
          if (tx_cnt_q == c_ana_last) begin
            tx_state_d = TX_WAIT_CAL;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + 20'd1;
          end
        end
        TX_WAIT_CAL: begin
          if (w_tx_ok) begin
            tx_state_d = TX_DIG_RST;
            tx_cnt_d   = '0;
          end
        end
        TX_DIG_RST: begin
          if (!w_tx_ok) begin
            tx_cnt_d = '0;
          end else if (tx_cnt_q == c_dig_last) begin
            tx_state_d = TX_READY;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + 20'd1;
          end
        end
        TX_READY: begin
          if (!w_tx_locked) begin
            tx_state_d = TX_ANA_RST;
            tx_cnt_d   = '0;
          end
        end
        default: begin
          tx_state_d = TX_ANA_RST;
          tx_cnt_d   = '0;
        end
      endcase
    end
  end

  rx_state_t   rx_state_q, rx_state_d;
  logic [19:0] rx_cnt_q, rx_cnt_d;
  logic [19:0] rx_tmo_q, rx_tmo_d;
  logic [7:0]  rx_timeouts_q, rx_timeouts_d;

  // rx_cnt_q times the analog/digital holds and the lock settle window;
  // rx_tmo_q only runs inside RX_WAIT_LOCK.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_tmo_d      = rx_tmo_q;
    rx_timeouts_d = rx_timeouts_q;
    if (rst_req_i) begin
      rx_state_d = RX_ANA_RST;
      rx_cnt_d   = '0;
      rx_tmo_d   = '0;
    end else begin
      case (rx_state_q)
        RX_ANA_RST: begin
          if (rx_cnt_q == c_ana_last) begin
            rx_state_d = RX_WAIT_CAL;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + 20'd1;
          end
        end
        RX_WAIT_CAL: begin
          if (!w_rx_cal) begin
            rx_state_d = RX_WAIT_LOCK;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
          end
        end
        RX_WAIT_LOCK: begin
          if (w_rx_cal) begin
            rx_state_d = RX_WAIT_CAL;
            rx_cnt_d   = '0;
          end else if (w_rx_locked && rx_cnt_q == c_settle_last) begin
            rx_state_d = RX_DIG_RST;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
          end else if (rx_tmo_q == c_tmo_last) begin
            rx_state_d = RX_ANA_RST;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
            if (rx_timeouts_q != 8'hFF) begin
              rx_timeouts_d = rx_timeouts_q + 8'd1;
            end
          end else begin
            rx_tmo_d = rx_tmo_q + 20'd1;
            rx_cnt_d = w_rx_locked ? rx_cnt_q + 20'd1 : '0;
          end
        end
        RX_DIG_RST: begin
          if (w_rx_cal) begin
            rx_state_d = RX_WAIT_CAL;
            rx_cnt_d   = '0;
          end else if (!w_rx_locked) begin
            rx_state_d = RX_WAIT_LOCK;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
          end else if (rx_cnt_q == c_dig_last) begin
            rx_state_d = RX_READY;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + 20'd1;
          end
        end
        RX_READY: begin
          if (w_rx_cal) begin
            rx_state_d = RX_WAIT_CAL;
            rx_cnt_d   = '0;
          end else if (!w_rx_locked) begin
            rx_state_d = RX_WAIT_LOCK;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
          end
        end
        default: begin
          rx_state_d = RX_ANA_RST;
          rx_cnt_d   = '0;
          rx_tmo_d   = '0;
        end
      endcase
    end
  end

  logic tx_ana_q, tx_dig_q, tx_rdy_q;
  logic rx_ana_q, rx_dig_q, rx_rdy_q;

  // Outputs are registered from the next state so each one flips on the
  // same edge that enters its state.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q    <= TX_ANA_RST;
      tx_cnt_q      <= '0;
      rx_state_q    <= RX_ANA_RST;
      rx_cnt_q      <= '0;
      rx_tmo_q      <= '0;
      rx_timeouts_q <= '0;
      tx_ana_q      <= 1'b1;
      tx_dig_q      <= 1'b1;
      tx_rdy_q      <= 1'b0;
      rx_ana_q      <= 1'b1;
      rx_dig_q      <= 1'b1;
      rx_rdy_q      <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_tmo_q      <= rx_tmo_d;
      rx_timeouts_q <= rx_timeouts_d;
      tx_ana_q      <= (tx_state_d == TX_ANA_RST);
      tx_dig_q      <= (tx_state_d != TX_READY);
      tx_rdy_q      <= (tx_state_d == TX_READY);
      rx_ana_q      <= (rx_state_d == RX_ANA_RST);
      rx_dig_q      <= (rx_state_d != RX_READY);
      rx_rdy_q      <= (rx_state_d == RX_READY);
    end
  end

  assign tx_analogreset_o  = tx_ana_q;
  assign tx_digitalreset_o = tx_dig_q;
  assign tx_ready_o        = tx_rdy_q;
  assign rx_analogreset_o  = rx_ana_q;
  assign rx_digitalreset_o = rx_dig_q;
  assign rx_ready_o        = rx_rdy_q;
  assign rx_timeouts_o     = rx_timeouts_q;

endmodule

`default_nettype wire
